// File: rtl/gpio_pad_ctrl_if.sv
// Request/response port of gpio_pad_ctrl: single-outstanding valid/ready
// request channel plus a held response channel.
interface gpio_pad_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// Per-pin register-mapped pad controller: drives bidir pad controls, synchronises
// pad inputs, detects edges into W1C pending flags and a registered level irq.
module gpio_pad_ctrl #(
  parameter int NUM_PADS = 40,
  parameter int ADDR_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  gpio_pad_ctrl_if.slave      bus,
  input  logic [NUM_PADS-1:0] bidir_in,
  output logic [NUM_PADS-1:0] bidir_out,
  output logic [NUM_PADS-1:0] bidir_oe,
  output logic [NUM_PADS-1:0] bidir_ie,
  output logic [NUM_PADS-1:0] bidir_cs,
  output logic [NUM_PADS-1:0] bidir_sl,
  output logic [NUM_PADS-1:0] bidir_pu,
  output logic [NUM_PADS-1:0] bidir_pd,
  output logic                irq
);

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t r_state, w_state_nxt;

  logic [NUM_PADS-1:0] r_out, r_oe, r_ie, r_pu, r_pd, r_cs, r_sl;
  logic [NUM_PADS-1:0] r_rise_en, r_fall_en, r_pend;
  logic [NUM_PADS-1:0] r_s1, r_s2, r_s3;
  logic                r_irq;
  logic [15:0]         r_rdata;

  logic                w_accept;
  logic [NUM_PADS-1:0] w_hit, w_wmask, w_clr, w_set;
  logic [15:0]         w_rd_word;
  logic [15:0]         w_wd;
  logic                w_unused_wdata;

  assign w_wd           = bus.req_wdata;
  assign w_unused_wdata = ^w_wd[15:10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Out-of-range addresses match no pin: writes vanish and reads return 0.
  always_comb begin
    w_hit     = '0;
    w_rd_word = '0;
    for (int unsigned i = 0; i < NUM_PADS; i++) begin
      if (bus.req_addr == ADDR_W'(i)) begin
        w_hit[i]  = 1'b1;
        w_rd_word = {5'b0, r_s2[i], r_pend[i], r_fall_en[i], r_rise_en[i],
                     r_sl[i], r_cs[i], r_pd[i], r_pu[i], r_ie[i], r_oe[i], r_out[i]};
      end
    end
  end

  assign w_wmask = (w_accept && bus.req_write) ? w_hit : '0;
  assign w_clr   = w_wd[9] ? w_wmask : '0;
  assign w_set   = (r_rise_en & r_s2 & ~r_s3) | (r_fall_en & ~r_s2 & r_s3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out     <= '0;
      r_oe      <= '0;
      r_ie      <= '1;
      r_pu      <= '0;
      r_pd      <= '0;
      r_cs      <= '0;
      r_sl      <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_pend    <= '0;
      r_s1      <= '0;
      r_s2      <= '0;
      r_s3      <= '0;
      r_irq     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_out     <= (r_out     & ~w_wmask) | (w_wmask & {NUM_PADS{w_wd[0]}});
      r_oe      <= (r_oe      & ~w_wmask) | (w_wmask & {NUM_PADS{w_wd[1]}});
      r_ie      <= (r_ie      & ~w_wmask) | (w_wmask & {NUM_PADS{w_wd[2]}});
      r_pu      <= (r_pu      & ~w_wmask) | (w_wmask & {NUM_PADS{w_wd[3]}});
      r_pd      <= (r_pd      & ~w_wmask) | (w_wmask & {NUM_PADS{w_wd[4]}});
      r_cs      <= (r_cs      & ~w_wmask) | (w_wmask & {NUM_PADS{w_wd[5]}});
      r_sl      <= (r_sl      & ~w_wmask) | (w_wmask & {NUM_PADS{w_wd[6]}});
      r_rise_en <= (r_rise_en & ~w_wmask) | (w_wmask & {NUM_PADS{w_wd[7]}});
      r_fall_en <= (r_fall_en & ~w_wmask) | (w_wmask & {NUM_PADS{w_wd[8]}});
      // A new edge outranks a simultaneous W1C.
      r_pend    <= w_set | (r_pend & ~w_clr);
      r_s1      <= bidir_in;
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      r_irq     <= |r_pend;
      if (w_accept) r_rdata <= bus.req_write ? '0 : w_rd_word;
    end
  end

  assign bus.rsp_rdata = r_rdata;
  assign bidir_out     = r_out;
  assign bidir_oe      = r_oe;
  assign bidir_ie      = r_ie;
  assign bidir_cs      = r_cs;
  assign bidir_sl      = r_sl;
  assign bidir_pu      = r_pu;
  assign bidir_pd      = r_pd & ~r_pu;
  assign irq           = r_irq;

endmodule
